// File: rtl/hazard_fwd_ctrl_if.sv
// Hazard/forwarding control bus: ID-stage sources, EX/MEM destinations and
// the stall/forward controls returned to the pipeline.
interface hazard_fwd_ctrl_if #(
  parameter int REG_W = 4,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) ();
  logic [3:0]            opCode_ID;
  logic [NSRC*REG_W-1:0] rdReg_ID;
  logic [REG_W-1:0]      wrReg_EX;
  logic                  wrEn_EX;
  logic                  isLoad_EX;
  logic [REG_W-1:0]      wrReg_MEM;
  logic                  wrEn_MEM;
  logic                  isLoad_MEM;
  logic                  mem_ready;
  logic                  flush;
  logic [2*NSRC-1:0]     hazSel_EX;
  logic                  stall_pc;
  logic                  stall_id;
  logic                  bubble_ex;
  logic                  freeze;
  logic [CNT_W-1:0]      stall_cnt;

  // Pipeline side: supplies stage information, consumes controls.
  modport master (
    output opCode_ID, rdReg_ID, wrReg_EX, wrEn_EX, isLoad_EX,
    output wrReg_MEM, wrEn_MEM, isLoad_MEM, mem_ready, flush,
    input  hazSel_EX, stall_pc, stall_id, bubble_ex, freeze, stall_cnt
  );

  // Controller side.
  modport slave (
    input  opCode_ID, rdReg_ID, wrReg_EX, wrEn_EX, isLoad_EX,
    input  wrReg_MEM, wrEn_MEM, isLoad_MEM, mem_ready, flush,
    output hazSel_EX, stall_pc, stall_id, bubble_ex, freeze, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding controller.
// Computes per-source forward selects for EX (registered), detects load-use
// hazards and waits on slow memory loads, driving the stall/bubble/freeze
// controls combinationally from the FSM state and current inputs.
module hazard_fwd_ctrl #(
  parameter int REG_W  = 4,
  parameter int NSRC   = 2,
  parameter int LU_CYC = 1,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  hazard_fwd_ctrl_if.slave bus
);

  // Opcodes whose source fields are not register reads.
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int               SEL_W   = 2 * NSRC;
  localparam logic [SEL_W-1:0] SEL_RF  = {SEL_W{1'b1}};
  localparam logic [2:0]       LU_INIT = 3'(LU_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [2:0]       lu_cnt_r;
  logic [2:0]       lu_cnt_nxt_s;
  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] sel_nxt_s;
  logic [1:0]       sel_i_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             forced_s;
  logic             lu_s;
  logic             memwait_s;
  logic             stall_pc_s;
  logic             stall_id_s;
  logic             bubble_ex_s;
  logic             freeze_s;

  // Forward select for one source: EX beats MEM, r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] ex_rd,
    input logic             ex_we,
    input logic [REG_W-1:0] mem_rd,
    input logic             mem_we
  );
    logic [1:0] sel;
    if (src == {REG_W{1'b0}}) begin
      sel = 2'b11;
    end else if (ex_we && (src == ex_rd)) begin
      sel = 2'b00;
    end else if (mem_we && (src == mem_rd)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b11;
    end
    return sel;
  endfunction

  assign memwait_s = bus.isLoad_MEM & ~bus.mem_ready;

  // Decode opcodes that must read the register file for every source.
  always_comb begin
    case (bus.opCode_ID)
      OP_LLB, OP_JAL, OP_HLT, OP_B: forced_s = 1'b1;
      default:                      forced_s = 1'b0;
    endcase
  end

  // Next forward selects and load-use detection across all sources.
  always_comb begin
    sel_nxt_s = SEL_RF;
    sel_i_s   = 2'b11;
    lu_s      = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (forced_s) begin
        sel_i_s = 2'b11;
      end else begin
        sel_i_s = fwd_sel(bus.rdReg_ID[i*REG_W +: REG_W], bus.wrReg_EX,
                          bus.wrEn_EX, bus.wrReg_MEM, bus.wrEn_MEM);
      end
      sel_nxt_s[2*i +: 2] = sel_i_s;
      // A select of 00 already implies EX writes a non-zero matching id.
      lu_s = lu_s | (bus.isLoad_EX & (sel_i_s == 2'b00));
    end
  end

  // Stall FSM: next state, bubble count and stall controls.
  always_comb begin
    state_nxt_s  = state_r;
    lu_cnt_nxt_s = lu_cnt_r;
    stall_pc_s   = 1'b0;
    stall_id_s   = 1'b0;
    bubble_ex_s  = 1'b0;
    freeze_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (memwait_s) begin
          freeze_s    = 1'b1;
          stall_pc_s  = 1'b1;
          stall_id_s  = 1'b1;
          state_nxt_s = MEM_WAIT;
        end else if (lu_s && !bus.flush) begin
          stall_pc_s  = 1'b1;
          stall_id_s  = 1'b1;
          bubble_ex_s = 1'b1;
          if (LU_CYC > 1) begin
            state_nxt_s  = LU_STALL;
            lu_cnt_nxt_s = LU_INIT;
          end else begin
            state_nxt_s  = IDLE;
            lu_cnt_nxt_s = 3'd0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LU_STALL: begin
        if (bus.flush) begin
          state_nxt_s  = IDLE;
          lu_cnt_nxt_s = 3'd0;
        end else begin
          stall_pc_s  = 1'b1;
          stall_id_s  = 1'b1;
          bubble_ex_s = 1'b1;
          if (lu_cnt_r <= 3'd1) begin
            state_nxt_s  = IDLE;
            lu_cnt_nxt_s = 3'd0;
          end else begin
            lu_cnt_nxt_s = lu_cnt_r - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_nxt_s = IDLE;
        end else begin
          freeze_s   = 1'b1;
          stall_pc_s = 1'b1;
          stall_id_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        lu_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // State and bubble-count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      lu_cnt_r <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      lu_cnt_r <= lu_cnt_nxt_s;
    end
  end

  // Forward-select register: hold on freeze, register file on bubble/flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_r <= SEL_RF;
    end else if (freeze_s) begin
      sel_r <= sel_r;
    end else if (bubble_ex_s || bus.flush) begin
      sel_r <= SEL_RF;
    end else begin
      sel_r <= sel_nxt_s;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_pc_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.hazSel_EX = sel_r;
  assign bus.stall_pc  = stall_pc_s;
  assign bus.stall_id  = stall_id_s;
  assign bus.bubble_ex = bubble_ex_s;
  assign bus.freeze    = freeze_s;
  assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: instance a uses defaults (LU_CYC=1,
// CNT_W=16); instance b uses LU_CYC=3, CNT_W=4 for multi-cycle load-use,
// flush abort and counter saturation.
module tb_hazard_fwd_ctrl;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_JAL = 4'hD;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_fwd_ctrl_if #(.REG_W(4), .NSRC(2), .CNT_W(16)) a_if ();
  hazard_fwd_ctrl_if #(.REG_W(4), .NSRC(2), .CNT_W(4))  b_if ();

  hazard_fwd_ctrl #(.REG_W(4), .NSRC(2), .LU_CYC(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );
  hazard_fwd_ctrl #(.REG_W(4), .NSRC(2), .LU_CYC(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic [3:0] op, input logic [7:0] ids,
                       input logic [3:0] ex_rd, input logic ex_we, input logic ex_ld,
                       input logic [3:0] mem_rd, input logic mem_we, input logic mem_ld,
                       input logic rdy, input logic fl);
    a_if.opCode_ID = op;     a_if.rdReg_ID  = ids;
    a_if.wrReg_EX  = ex_rd;  a_if.wrEn_EX   = ex_we;  a_if.isLoad_EX  = ex_ld;
    a_if.wrReg_MEM = mem_rd; a_if.wrEn_MEM  = mem_we; a_if.isLoad_MEM = mem_ld;
    a_if.mem_ready = rdy;    a_if.flush     = fl;
  endtask

  task automatic set_b(input logic [3:0] op, input logic [7:0] ids,
                       input logic [3:0] ex_rd, input logic ex_we, input logic ex_ld,
                       input logic [3:0] mem_rd, input logic mem_we, input logic mem_ld,
                       input logic rdy, input logic fl);
    b_if.opCode_ID = op;     b_if.rdReg_ID  = ids;
    b_if.wrReg_EX  = ex_rd;  b_if.wrEn_EX   = ex_we;  b_if.isLoad_EX  = ex_ld;
    b_if.wrReg_MEM = mem_rd; b_if.wrEn_MEM  = mem_we; b_if.isLoad_MEM = mem_ld;
    b_if.mem_ready = rdy;    b_if.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with quiet inputs
    rst_n = 1'b0;
    set_a(OP_ADD, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    set_b(OP_ADD, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); step();
    chk("rst_sel_a", a_if.hazSel_EX, 4'hF);
    chk("rst_cnt_a", a_if.stall_cnt, 16'd0);
    chk("rst_sel_b", b_if.hazSel_EX, 4'hF);
    chk("rst_cnt_b", b_if.stall_cnt, 4'd0);
    @(negedge clk);
    chk("rst_stall_a", a_if.stall_pc, 1'b0);
    chk("rst_freeze_a", a_if.freeze, 1'b0);
    step();
    rst_n = 1'b1;

    // ID r4,r3; EX writes r3 (ALU), MEM writes r4
    set_a(OP_ADD, {4'd4, 4'd3}, 4'd3, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fwd_nostall", a_if.stall_pc, 1'b0);
    chk("fwd_nobubble", a_if.bubble_ex, 1'b0);
    step();
    chk("fwd_sel", a_if.hazSel_EX, 4'b0100);

    // Both stages write r3: EX wins
    set_a(OP_ADD, {4'd3, 4'd3}, 4'd3, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("ex_prio", a_if.hazSel_EX, 4'b0000);

    // r0 never forwards, src0=r7 from MEM
    set_a(OP_ADD, {4'd0, 4'd7}, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("r0_sel", a_if.hazSel_EX, 4'b1101);

    // EX matches but does not write: fall through to MEM
    set_a(OP_ADD, {4'd3, 4'd3}, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("ex_nowr", a_if.hazSel_EX, 4'b0101);

    // Load-use on r5 with one bubble cycle
    set_a(OP_ADD, {4'd0, 4'd5}, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lu_stall_pc", a_if.stall_pc, 1'b1);
    chk("lu_stall_id", a_if.stall_id, 1'b1);
    chk("lu_bubble", a_if.bubble_ex, 1'b1);
    chk("lu_nofreeze", a_if.freeze, 1'b0);
    step();
    chk("lu_sel", a_if.hazSel_EX, 4'hF);
    chk("lu_cnt", a_if.stall_cnt, 16'd1);

    // Load moves to MEM with data valid: forward from WB
    set_a(OP_ADD, {4'd0, 4'd5}, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lu_done", a_if.stall_pc, 1'b0);
    chk("lu_done_bub", a_if.bubble_ex, 1'b0);
    step();
    chk("lu_after_sel", a_if.hazSel_EX, 4'b1101);
    chk("lu_after_cnt", a_if.stall_cnt, 16'd1);

    // Memory wait for 3 cycles: freeze and hold selects
    set_a(OP_ADD, 8'h00, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mw_freeze", a_if.freeze, 1'b1);
      chk("mw_stall_pc", a_if.stall_pc, 1'b1);
      chk("mw_nobubble", a_if.bubble_ex, 1'b0);
      step();
      chk("mw_hold", a_if.hazSel_EX, 4'b1101);
    end
    set_a(OP_ADD, 8'h00, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("mw_rdy_freeze", a_if.freeze, 1'b0);
    chk("mw_rdy_stall", a_if.stall_pc, 1'b0);
    step();
    chk("mw_rdy_sel", a_if.hazSel_EX, 4'hF);
    chk("mw_cnt", a_if.stall_cnt, 16'd4);

    // Non-forced ALU forward, then JAL with matching EX load
    set_a(OP_ADD, {4'd6, 4'd6}, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("pre_jal_sel", a_if.hazSel_EX, 4'b0000);
    set_a(OP_JAL, {4'd0, 4'd6}, 4'd6, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("jal_nostall", a_if.stall_pc, 1'b0);
    step();
    chk("jal_sel", a_if.hazSel_EX, 4'hF);
    chk("jal_cnt", a_if.stall_cnt, 16'd4);

    // Load into r0 never stalls
    set_a(OP_ADD, 8'h00, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("r0_load", a_if.stall_pc, 1'b0);
    step();

    // Load-use suppressed by flush
    set_a(OP_ADD, {4'd0, 4'd6}, 4'd6, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_lu_stall", a_if.stall_pc, 1'b0);
    chk("flush_lu_bub", a_if.bubble_ex, 1'b0);
    step();

    // Reset in the middle of a memory wait
    set_a(OP_ADD, 8'h00, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    @(negedge clk);
    chk("mw2_freeze", a_if.freeze, 1'b1);
    step();
    chk("mw2_cnt", a_if.stall_cnt, 16'd6);
    rst_n = 1'b0;
    step();
    chk("mw_rst_cnt", a_if.stall_cnt, 16'd0);
    chk("mw_rst_sel", a_if.hazSel_EX, 4'hF);
    rst_n = 1'b1;
    set_a(OP_ADD, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("mw_rst_freeze", a_if.freeze, 1'b0);
    chk("mw_rst_stall", a_if.stall_pc, 1'b0);
    step();
    chk("mw_rst_cnt2", a_if.stall_cnt, 16'd0);

    // Instance b: three-cycle load-use
    set_b(OP_ADD, {4'd0, 4'd2}, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lu3_stall", b_if.stall_pc, 1'b1);
      chk("lu3_bubble", b_if.bubble_ex, 1'b1);
      step();
      chk("lu3_sel", b_if.hazSel_EX, 4'hF);
    end
    set_b(OP_ADD, {4'd0, 4'd2}, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lu3_done", b_if.stall_pc, 1'b0);
    step();
    chk("lu3_sel_after", b_if.hazSel_EX, 4'b1101);
    chk("lu3_cnt", b_if.stall_cnt, 4'd3);

    // Flush on the second stall cycle aborts the load-use stall
    set_b(OP_ADD, {4'd0, 4'd2}, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_first", b_if.stall_pc, 1'b1);
    step();
    set_b(OP_ADD, {4'd0, 4'd2}, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_stall", b_if.stall_pc, 1'b0);
    chk("fl_bubble", b_if.bubble_ex, 1'b0);
    step();
    chk("fl_sel", b_if.hazSel_EX, 4'hF);
    set_b(OP_ADD, {4'd0, 4'd2}, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_idle", b_if.stall_pc, 1'b0);
    step();
    chk("fl_cnt", b_if.stall_cnt, 4'd4);

    // Reset in the middle of a load-use stall
    set_b(OP_ADD, {4'd0, 4'd2}, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    chk("lu_rst_cnt", b_if.stall_cnt, 4'd0);
    rst_n = 1'b1;
    set_b(OP_ADD, {4'd0, 4'd2}, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lu_rst_stall", b_if.stall_pc, 1'b0);
    chk("lu_rst_bubble", b_if.bubble_ex, 1'b0);
    step();

    // Saturation of the 4-bit stall counter through a long memory wait
    set_b(OP_ADD, 8'h00, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (14) step();
    chk("sat_14", b_if.stall_cnt, 4'd14);
    repeat (3) step();
    chk("sat_15", b_if.stall_cnt, 4'd15);
    set_b(OP_ADD, 8'h00, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("sat_freeze", b_if.freeze, 1'b0);
    step();
    chk("sat_hold", b_if.stall_cnt, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- REG_W, 4, register-id width.
- NSRC, 2, source operands per instruction.
- LU_CYC, 1, load-use bubble cycles (1..7).
- CNT_W, 16, stall-counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk in 1 clock.
- rst_n in 1 synchronous active-low reset.
- opCode_ID in 4 opcode in ID.
- rdReg_ID in NSRC*REG_W source ids in ID; source i at [i*REG_W +: REG_W].
- wrReg_EX in REG_W EX destination.
- wrEn_EX in 1 EX writes.
- isLoad_EX in 1 EX is a load.
- wrReg_MEM in REG_W MEM destination.
- wrEn_MEM in 1 MEM writes.
- isLoad_MEM in 1 MEM is a load.
- mem_ready in 1 load data valid this cycle.
- flush in 1 branch redirect; squash IF/ID.
- hazSel_EX out 2*NSRC per-source forward select for EX, registered.
- stall_pc out 1 hold PC.
- stall_id out 1 hold IF/ID.
- bubble_ex out 1 insert NOP into EX.
- freeze out 1 hold all stages.
- stall_cnt out CNT_W saturating count of stalled cycles.
REQ-003 Clock SHALL be one clock, clk; reset SHALL be synchronous, active-low, rst_n.

Function
REQ-004 Select encoding per source SHALL be 2'b00 forward MEM result, 2'b01 forward WB result, 2'b11 register file.
REQ-005 Next select for source i (src) SHALL be 00 if src==wrReg_EX & wrEn_EX & src!=0; else 01 if src==wrReg_MEM & wrEn_MEM & src!=0; else 11. EX match SHALL have priority over MEM.
REQ-006 Next select SHALL be forced to 11 for every source when opCode_ID is `LLB, `JAL, `HLT or `B.
REQ-007 Load-use (lu) SHALL be true when any source i has src==wrReg_EX & wrEn_EX & isLoad_EX & src!=0 and the opcode is not forced per REQ-006.
REQ-008 FSM states SHALL be IDLE, LU_STALL, MEM_WAIT. memwait = isLoad_MEM & !mem_ready.
REQ-009 IDLE behaviour:
- memwait -> freeze=1, go MEM_WAIT (priority over lu).
- else lu & !flush -> stall_pc=stall_id=bubble_ex=1; go LU_STALL with bubble count LU_CYC-1 if LU_CYC>1, else stay IDLE.
REQ-010 LU_STALL SHALL assert stall_pc, stall_id, bubble_ex each cycle, decrement the count, and return to IDLE after the count reaches 0; flush SHALL abort to IDLE the same cycle with stall outputs 0.
REQ-011 MEM_WAIT SHALL assert freeze=stall_pc=stall_id=1, bubble_ex=0, until mem_ready=1; in that cycle freeze SHALL drop and the state SHALL go to IDLE. flush SHALL be ignored in MEM_WAIT.
REQ-012 hazSel_EX update rule, in priority order:
- freeze=1 -> hold.
- bubble_ex=1 or flush=1 -> load all-11.
- else -> load next select (REQ-005/006).
REQ-013 Outputs stall_pc, stall_id, bubble_ex, freeze SHALL be combinational from state and inputs with no added latency; hazSel_EX SHALL have 1-cycle latency.
REQ-014 stall_cnt SHALL increment by 1 each cycle stall_pc=1 and saturate at all-ones.
REQ-015 All register-id compares SHALL be REG_W wide; id 0 SHALL never forward or stall.

Reset
REQ-016 rst_n=0 at a clk edge SHALL set state=IDLE, hazSel_EX all-1s, stall_cnt=0, LU count=0; combinational outputs SHALL follow state IDLE.
REQ-017 Reset SHALL take effect mid-LU_STALL or mid-MEM_WAIT, with no residual stall after release.

Verification
REQ-018 ID r3,r4; EX wrReg=3 wrEn=1 isLoad=0; MEM wrReg=4 wrEn=1 -> next cycle hazSel_EX=4'b0100 (src1=01, src0=00), no stall.
REQ-019 ID r5; EX load to r5, LU_CYC=1 -> stall_pc=stall_id=bubble_ex=1 one cycle, hazSel_EX=11 bubble; next cycle (load in MEM) hazSel src0=01.
REQ-020 isLoad_MEM=1, mem_ready=0 for 3 cycles then 1 -> freeze=1 exactly 3 cycles, hazSel_EX held, stall_cnt +3, then IDLE.
REQ-021 LU_CYC=3, lu detected, flush asserted on 2nd stall cycle -> stalls total 1 cycle after detection cycle, hazSel_EX=all-11, state IDLE.
REQ-022 opCode_ID=`JAL with src matching EX load -> no stall, hazSel_EX=all-11; src=r0 matching wrReg_EX=0 -> 11.
REQ-023 stall_cnt preset near max (CNT_W=4, 15) plus stall -> stays 15; rst_n=0 in MEM_WAIT -> IDLE, freeze=0, stall_cnt=0.
